fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count; power of two, minimum 4.
REQ-002 SHALL have parameter PC_W, default 32, PC width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-006 SHALL have port push_cnt  in  2  instructions offered by fetch this cycle (0..2; 3 treated as 2).
REQ-007 SHALL have port in_instr0, in_instr1  in  32 each  fetched instructions in program order.
REQ-008 SHALL have port in_pc  in  PC_W  PC of in_instr0; in_instr1 is at in_pc+4.
REQ-009 SHALL have port in_ready  out  1  high when at least 2 entries are free.
REQ-010 SHALL have port issue_cnt  in  2  instructions consumed by decode this cycle (0..2).
REQ-011 SHALL have port flush  in  1  branch/jump redirect; discard all contents.
REQ-012 SHALL have ports instruction1, instruction2  out  32 each  oldest and second-oldest entries, feeding decode slot 1 and slot 2.
REQ-013 SHALL have ports pc1, pc2  out  PC_W each  PCs of instruction1 and instruction2.
REQ-014 SHALL have ports valid1, valid2  out  1 each  slot holds a live instruction; valid2 implies valid1.
REQ-015 SHALL have port count  out  log2(DEPTH)+1  current occupancy.

Function
REQ-016 SHALL be a circular buffer with head and tail pointers of log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty and wraps modulo 2*DEPTH.
REQ-017 SHALL accept a push only when in_ready is high; when in_ready is low, push_cnt is ignored and no state changes.
REQ-018 SHALL write in_instr0/in_pc at tail for push_cnt>=1, and in_instr1/in_pc+4 at tail+1 for push_cnt=2; tail then advances by the accepted count.
REQ-019 SHALL advance head by min(issue_cnt, valid1+valid2); an excess issue_cnt is clamped and never underflows.
REQ-020 SHALL apply push and pop together in one cycle: count_next = count + pushed - popped.
REQ-021 SHALL drive instruction1/2 and pc1/2 combinationally from head and head+1; it SHALL assert valid1 when count>=1 and valid2 when count>=2.
REQ-022 SHALL drive the NOP constant (32'h0) on an invalid slot's instruction output and 0 on its pc output.
REQ-023 SHALL make a pushed entry visible on the outputs in the cycle after the push (1-cycle latency) unless bypass is enabled.
REQ-024 SHALL, when flush is high, set head=tail=0 and count=0 on that edge, dropping any same-cycle push and issue; flush has the highest priority.
REQ-025 SHALL wrap entries across index DEPTH-1 to 0 without gaps, including a push_cnt=2 write that straddles the wrap.

Reset
REQ-026 SHALL, while rst is low, force head=0, tail=0 and count=0, giving valid1=valid2=0, instruction1/2=NOP, pc1/2=0 and in_ready=1.
REQ-027 SHALL discard any in-flight push or issue when reset is asserted mid-operation; storage contents need not be cleared.

Configuration
REQ-028 SHALL, with FETCH_QUEUE_BYPASS_EN defined and the queue empty, present same-cycle pushed instructions directly on instruction1/2 with valid bits set.
REQ-029 SHALL, with FETCH_QUEUE_BYPASS_EN defined, not write bypassed instructions consumed by issue_cnt in the same cycle; only the unconsumed remainder is stored.
REQ-030 SHALL, without FETCH_QUEUE_BYPASS_EN, give outputs that depend only on registered state, per REQ-023.

Structure
REQ-031 SHALL take the NOP constant, INSTR_W=32 and the pointer-width function from shared package fetch_pkg.
REQ-032 SHALL place the storage array (2 write ports, 2 read ports, async read) in sub-module fetch_queue_storage; pointer and count logic SHALL stay in fetch_queue.

Verification
REQ-033 SHALL be verified by: reset, then push_cnt=2 with 0x20080005/0x20090007 at in_pc=0x0 -> next cycle valid1=valid2=1, pc1=0x0, pc2=0x4, count=2.
REQ-034 SHALL be verified by: fill to count=7 -> in_ready=0; a push_cnt=2 is ignored, count stays 7; issue_cnt=1 -> count=6, in_ready=1.
REQ-035 SHALL be verified by: count=1 with issue_cnt=2 -> count=0, valid1=0, instruction1=0x00000000.
REQ-036 SHALL be verified by: count=5, then flush=1 together with push_cnt=2 and issue_cnt=2 -> count=0 next cycle, no valid outputs.
REQ-037 SHALL be verified by: tail at index 7, push_cnt=2 -> entries land in indices 7 and 0 and issue out in order with pcs N, N+4.
REQ-038 SHALL be verified by: with FETCH_QUEUE_BYPASS_EN, empty queue, push_cnt=2 and issue_cnt=1 in the same cycle -> instruction1=in_instr0 that cycle; count=1 next cycle holding in_instr1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants for the fetch queue: instruction width, NOP encoding, pointer sizing.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;

  typedef logic [INSTR_W-1:0] instr_t;

  localparam instr_t NOP = 32'h0000_0000;

  // One extra MSB beyond the index bits separates full from empty.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_storage.sv
// Entry storage for the fetch queue: two write ports, two asynchronous read ports.
module fetch_queue_storage #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1
);

  logic [DATA_W-1:0] mem [DEPTH];

  // The two write addresses are always consecutive, so they never collide.
  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue instruction fetch queue (circular buffer, 2-in / 2-out per cycle).
// Optional same-cycle bypass into an empty queue: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PC_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                push_cnt,
  input  logic [INSTR_W-1:0]        in_instr0,
  input  logic [INSTR_W-1:0]        in_instr1,
  input  logic [PC_W-1:0]           in_pc,
  output logic                      in_ready,
  input  logic [1:0]                issue_cnt,
  input  logic                      flush,
  output logic [INSTR_W-1:0]        instruction1,
  output logic [INSTR_W-1:0]        instruction2,
  output logic [PC_W-1:0]           pc1,
  output logic [PC_W-1:0]           pc2,
  output logic                      valid1,
  output logic                      valid2,
  output logic [ptr_w(DEPTH)-1:0]   count
);

  localparam int unsigned PtrW  = ptr_w(DEPTH);
  localparam int unsigned AddrW = PtrW - 1;
  localparam int unsigned DataW = INSTR_W + PC_W;

  logic [PtrW-1:0]    head_q, tail_q, occ;
  logic [PtrW-1:0]    head_p1;
  logic [1:0]         push_req, pushed, stored_avail, avail, popped, skip, n_store, head_adv;
  logic               byp;
  logic [PC_W-1:0]    pc_plus4;
  logic               we0, we1;
  logic [DataW-1:0]   wdata0, wdata1, rdata0, rdata1;
  logic [INSTR_W-1:0] rd_instr0, rd_instr1;
  logic [PC_W-1:0]    rd_pc0, rd_pc1;

  assign occ      = tail_q - head_q;
  assign count    = occ;
  assign in_ready = (occ <= PtrW'(DEPTH - 2));
  assign head_p1  = head_q + PtrW'(1);
  assign pc_plus4 = in_pc + PC_W'(4);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = (occ == '0);
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    push_req     = (push_cnt == 2'd3) ? 2'd2 : push_cnt;
    pushed       = in_ready ? push_req : 2'd0;
    stored_avail = (occ >= PtrW'(2)) ? 2'd2 : occ[1:0];
    avail        = byp ? pushed : stored_avail;
    popped       = (issue_cnt > avail) ? avail : issue_cnt;
    // Bypassed instructions consumed this cycle are never written.
    skip         = byp ? popped : 2'd0;
    n_store      = pushed - skip;
    head_adv     = byp ? 2'd0 : popped;
  end

  assign we0    = !flush && (n_store != 2'd0);
  assign we1    = !flush && (n_store == 2'd2);
  assign wdata0 = (skip == 2'd0) ? {in_instr0, in_pc} : {in_instr1, pc_plus4};
  assign wdata1 = {in_instr1, pc_plus4};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (flush) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_q + PtrW'(head_adv);
      tail_q <= tail_q + PtrW'(n_store);
    end
  end

  fetch_queue_storage #(
    .DEPTH  (DEPTH),
    .DATA_W (DataW),
    .ADDR_W (AddrW)
  ) u_storage (
    .clk    (clk),
    .we0    (we0),
    .waddr0 (tail_q[AddrW-1:0]),
    .wdata0 (wdata0),
    .we1    (we1),
    .waddr1 (tail_q[AddrW-1:0] + AddrW'(1)),
    .wdata1 (wdata1),
    .raddr0 (head_q[AddrW-1:0]),
    .rdata0 (rdata0),
    .raddr1 (head_p1[AddrW-1:0]),
    .rdata1 (rdata1)
  );

  assign {rd_instr0, rd_pc0} = rdata0;
  assign {rd_instr1, rd_pc1} = rdata1;

  always_comb begin
    valid1       = (avail != 2'd0);
    valid2       = (avail == 2'd2);
    instruction1 = NOP;
    instruction2 = NOP;
    pc1          = '0;
    pc2          = '0;
    if (valid1) begin
      instruction1 = byp ? in_instr0 : rd_instr0;
      pc1          = byp ? in_pc : rd_pc0;
    end
    if (valid2) begin
      instruction2 = byp ? in_instr1 : rd_instr1;
      pc2          = byp ? pc_plus4 : rd_pc1;
    end
  end

endmodule
